// File: rtl/mult_sequencer.sv
// Keypad-driven operand entry and start/handshake sequencer for a signed 8-bit multiplier.
// Optional WAIT watchdog enabled by defining MULT_TIMEOUT_EN.
module mult_sequencer #(
  parameter int MAX_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       mult_ready,
  output logic [7:0] num_1,
  output logic [7:0] num_2,
  output logic       valid,
  output logic       busy,
  output logic       operand_sel,
  output logic [9:0] entry_mag,
  output logic       entry_neg,
  output logic       err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, START, WAIT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      num_1_reg, num_1_next;
  logic [7:0]      num_2_reg, num_2_next;
  logic [9:0]      mag_reg, mag_next;
  logic            neg_reg, neg_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            err_reg, err_next;

  logic [13:0]     mag_calc;
  logic [7:0]      op_val;
  logic            in_range;
  logic            is_digit;

`ifdef MULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;
`endif

  assign is_digit = (key_code <= 4'd9);
  assign mag_calc = 14'(mag_reg) * 14'd10 + 14'(key_code);
  // -128 fits only with the sign pending; 0 - 8'h80 wraps to 8'h80 as required.
  assign in_range = neg_reg ? (mag_reg <= 10'd128) : (mag_reg <= 10'd127);
  assign op_val   = neg_reg ? (8'd0 - mag_reg[7:0]) : mag_reg[7:0];

  always_comb begin
    state_next = state_reg;
    num_1_next = num_1_reg;
    num_2_next = num_2_reg;
    mag_next   = mag_reg;
    neg_next   = neg_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
`ifdef MULT_TIMEOUT_EN
    to_cnt_next = '0;
`endif
    case (state_reg)
      ENTRY_A, ENTRY_B: begin
        if (key_valid) begin
          if (is_digit) begin
            if (cnt_reg < CW'(MAX_DIGITS)) begin
              mag_next = mag_calc[9:0];
              cnt_next = cnt_reg + 1'b1;
            end
          end else if (key_code == 4'hA) begin
            neg_next = ~neg_reg;
          end else if (key_code == 4'hC || key_code == 4'hB) begin
            mag_next = '0;
            neg_next = 1'b0;
            cnt_next = '0;
            if (key_code == 4'hB) begin
              if (!in_range) begin
                err_next = 1'b1;
              end else if (state_reg == ENTRY_A) begin
                num_1_next = op_val;
                state_next = ENTRY_B;
              end else begin
                num_2_next = op_val;
                state_next = START;
              end
            end
          end
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (mult_ready) begin
          state_next = DONE;
        end
`ifdef MULT_TIMEOUT_EN
        else if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          err_next   = 1'b1;
          num_1_next = '0;
          num_2_next = '0;
          state_next = ENTRY_A;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
`endif
      end
      DONE: begin
        if (key_valid) begin
          if (is_digit) begin
            mag_next   = 10'(key_code);
            cnt_next   = CW'(1);
            state_next = ENTRY_A;
          end else if (key_code == 4'hA) begin
            neg_next   = 1'b1;
            state_next = ENTRY_A;
          end else if (key_code == 4'hB) begin
            state_next = START;
          end else if (key_code == 4'hC) begin
            state_next = ENTRY_A;
          end
        end
      end
      default: state_next = ENTRY_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ENTRY_A;
      num_1_reg <= '0;
      num_2_reg <= '0;
      mag_reg   <= '0;
      neg_reg   <= 1'b0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      to_cnt_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      num_1_reg <= num_1_next;
      num_2_reg <= num_2_next;
      mag_reg   <= mag_next;
      neg_reg   <= neg_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
`ifdef MULT_TIMEOUT_EN
      to_cnt_reg <= to_cnt_next;
`endif
    end
  end

  assign num_1       = num_1_reg;
  assign num_2       = num_2_reg;
  assign valid       = (state_reg == START);
  assign busy        = (state_reg == START) || (state_reg == WAIT);
  assign operand_sel = (state_reg != ENTRY_A);
  assign entry_mag   = mag_reg;
  assign entry_neg   = neg_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer; define MULT_TIMEOUT_EN to exercise the watchdog path.
module tb_mult_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       mult_ready = 1'b0;
  logic [7:0] num_1, num_2;
  logic       valid, busy, operand_sel, entry_neg, err;
  logic [9:0] entry_mag;

  int passes = 0;
  int total = 0;
  int valid_count = 0;

  mult_sequencer #(.MAX_DIGITS(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .mult_ready(mult_ready), .num_1(num_1), .num_2(num_2), .valid(valid),
    .busy(busy), .operand_sel(operand_sel), .entry_mag(entry_mag),
    .entry_neg(entry_neg), .err(err)
  );

  always #5 clk = ~clk;

  // valid is sampled at the edge, where the sequencer itself sees it
  always @(posedge clk) if (valid) valid_count <= valid_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    mult_ready = 1'b1;
    @(negedge clk);
    mult_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_num_1", 32'(num_1), 32'h0);
    check("rst_num_2", 32'(num_2), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_opsel", 32'(operand_sel), 32'h0);
    check("rst_mag", 32'(entry_mag), 32'h0);
    check("rst_neg", 32'(entry_neg), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // digit limit, ignored keys, sign toggle, clear
    press(4'h1); press(4'h2); press(4'h3);
    check("mag_123", 32'(entry_mag), 32'd123);
    press(4'h4);
    check("mag_4th_ignored", 32'(entry_mag), 32'd123);
    check("err_4th_digit", 32'(err), 32'h0);
    press(4'hD);
    check("key_d_ignored", 32'(entry_mag), 32'd123);
    press(4'hA);
    check("neg_toggle_full", 32'(entry_neg), 32'h1);
    press(4'hC);
    check("clear_mag", 32'(entry_mag), 32'h0);
    check("clear_neg", 32'(entry_neg), 32'h0);

    // out of range positive 129, then -128
    press(4'h1); press(4'h2); press(4'h9); press(4'hB);
    check("oor_err", 32'(err), 32'h1);
    check("oor_num_1", 32'(num_1), 32'h0);
    check("oor_opsel", 32'(operand_sel), 32'h0);
    check("oor_mag_clr", 32'(entry_mag), 32'h0);
    @(negedge clk);
    check("oor_err_pulse", 32'(err), 32'h0);
    press(4'hA); press(4'h1); press(4'h2); press(4'h8); press(4'hB);
    check("neg128_num_1", 32'(num_1), 32'h80);
    check("neg128_opsel", 32'(operand_sel), 32'h1);
    check("neg128_neg_clr", 32'(entry_neg), 32'h0);
    // +128 rejected in B, +127 accepted
    press(4'h1); press(4'h2); press(4'h8); press(4'hB);
    check("pos128_err", 32'(err), 32'h1);
    check("pos128_num_2", 32'(num_2), 32'h0);
    press(4'h1); press(4'h2); press(4'h7); press(4'hB);
    check("pos127_num_2", 32'(num_2), 32'h7F);
    check("pos127_valid", 32'(valid), 32'h1);

    // -12 x 5 handshake
    do_reset();
    pulse_ready();
    check("ready_ignored_entry", 32'(operand_sel), 32'h0);
    press(4'hA); press(4'hB);
    check("neg_empty_zero", 32'(num_1), 32'h0);
    do_reset();
    press(4'h1); press(4'h2); press(4'hA); press(4'hB);
    check("m12_num_1", 32'(num_1), 32'hF4);
    press(4'h5);
    valid_count = 0;
    press(4'hB);
    check("b5_num_2", 32'(num_2), 32'h05);
    check("start_valid", 32'(valid), 32'h1);
    check("start_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("wait_valid", 32'(valid), 32'h0);
    check("wait_busy", 32'(busy), 32'h1);
    press(4'h7);
    check("wait_key_ignored", 32'(entry_mag), 32'h0);
    pulse_ready();
    check("done_busy", 32'(busy), 32'h0);
    check("valid_once", 32'(valid_count), 32'd1);

    // DONE: re-issue, then new digit
    press(4'hB);
    check("reissue_valid", 32'(valid), 32'h1);
    check("reissue_num_1", 32'(num_1), 32'hF4);
    check("reissue_num_2", 32'(num_2), 32'h05);
    pulse_ready();
    press(4'h7);
    check("done7_opsel", 32'(operand_sel), 32'h0);
    check("done7_mag", 32'(entry_mag), 32'd7);
    check("done7_num_1_held", 32'(num_1), 32'hF4);

    // into WAIT with 7 x 0
    press(4'hB); press(4'hB);
    check("w_num_1", 32'(num_1), 32'h07);
    check("w_num_2_empty", 32'(num_2), 32'h0);
`ifdef MULT_TIMEOUT_EN
    repeat (8) @(negedge clk);
    check("to_not_yet_err", 32'(err), 32'h0);
    check("to_not_yet_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("to_err", 32'(err), 32'h1);
    check("to_opsel", 32'(operand_sel), 32'h0);
    check("to_num_1", 32'(num_1), 32'h0);
    check("to_num_2", 32'(num_2), 32'h0);
    press(4'hB); press(4'hB);
`else
    repeat (40) @(negedge clk);
    check("wait_holds", 32'(busy), 32'h1);
    check("wait_no_err", 32'(err), 32'h0);
`endif

    // reset mid-WAIT with competing key and ready pulses
    @(negedge clk);
    valid_count = 0;
    reset = 1'b0;
    key_valid = 1'b1; key_code = 4'hB; mult_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; mult_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pulse_ready();
    repeat (3) @(negedge clk);
    check("wrst_num_1", 32'(num_1), 32'h0);
    check("wrst_num_2", 32'(num_2), 32'h0);
    check("wrst_busy", 32'(busy), 32'h0);
    check("wrst_opsel", 32'(operand_sel), 32'h0);
    check("wrst_mag", 32'(entry_mag), 32'h0);
    check("wrst_err", 32'(err), 32'h0);
    check("wrst_no_valid", 32'(valid_count), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3, meaning max decimal digits accepted per operand.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning WAIT watchdog limit in clk cycles; used only with MULT_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port key_valid  input  1  one-cycle pulse marking a debounced keypad event.
REQ-006 SHALL have port key_code  input  4  key value: 0-9 digit, 4'hA sign toggle, 4'hB enter, 4'hC clear, 4'hD-F ignored.
REQ-007 SHALL have port mult_ready  input  1  one-cycle completion pulse from the multiplier FSM.
REQ-008 SHALL have port num_1  output  8  operand A, two's complement.
REQ-009 SHALL have port num_2  output  8  operand B, two's complement.
REQ-010 SHALL have port valid  output  1  one-cycle start pulse to the multiplier FSM.
REQ-011 SHALL have port busy  output  1  high in START and WAIT.
REQ-012 SHALL have port operand_sel  output  1  0 while entering A, 1 while entering B or later.
REQ-013 SHALL have port entry_mag  output  10  magnitude accumulated so far, for display echo.
REQ-014 SHALL have port entry_neg  output  1  pending sign of the operand being entered.
REQ-015 SHALL have port err  output  1  one-cycle pulse on rejected entry or timeout.

Function
REQ-016 SHALL implement states ENTRY_A, ENTRY_B, START, WAIT, DONE.
REQ-017 In ENTRY_x, a digit SHALL set entry_mag = entry_mag*10 + digit and increment the digit count; with digit count == MAX_DIGITS, further digits SHALL be ignored with no err.
REQ-018 In ENTRY_x, 4'hA SHALL toggle entry_neg regardless of digit count.
REQ-019 In ENTRY_x, 4'hC SHALL clear entry_mag, digit count and entry_neg, staying in the current state.
REQ-020 On enter, if entry_mag <= 127 (positive) or <= 128 (negative), the selected operand SHALL load the two's-complement value; ENTRY_A then goes to ENTRY_B and ENTRY_B goes to START.
REQ-021 Enter with no digits SHALL load 0, with the result +0 for either sign.
REQ-022 Enter out of range SHALL pulse err, clear the entry registers, leave the operand unchanged and keep the state.
REQ-023 Every transition out of ENTRY_x SHALL clear entry_mag, digit count and entry_neg in the same edge.
REQ-024 START SHALL last exactly one cycle with valid=1, then go to WAIT; valid SHALL be 0 in every other state.
REQ-025 num_1/num_2 SHALL be stable from START entry until ENTRY_A is re-entered or ENTRY_B accepts a new value.
REQ-026 WAIT SHALL ignore all key events and go to DONE on the cycle mult_ready is sampled high.
REQ-027 mult_ready outside WAIT SHALL be ignored.
REQ-028 In DONE, enter SHALL go to START, reissuing the same operands.
REQ-029 In DONE, clear SHALL go to ENTRY_A.
REQ-030 In DONE, a digit SHALL go to ENTRY_A with that digit loaded as the first digit.
REQ-031 In DONE, 4'hA SHALL go to ENTRY_A with entry_neg=1.
REQ-032 Key codes 4'hD-F SHALL have no effect in any state.
REQ-033 Each state SHALL process at most one key event per cycle, with outputs registered (1-cycle latency from key_valid).

Reset
REQ-034 With reset low at a clk edge, the block SHALL enter ENTRY_A with num_1=num_2=0, valid=0, busy=0, operand_sel=0, entry_mag=0, entry_neg=0, err=0, digit count=0 and timeout counter=0.
REQ-035 Reset SHALL take priority over key_valid and mult_ready, including mid-WAIT, with no valid emitted afterward.

Configuration
REQ-036 With MULT_TIMEOUT_EN defined, a counter SHALL run in WAIT; if mult_ready is absent for TIMEOUT_CYCLES cycles, the block SHALL pulse err and go to ENTRY_A with operands cleared.
REQ-037 Without MULT_TIMEOUT_EN, WAIT SHALL hold indefinitely and no timeout counter SHALL be present.

Verification
REQ-038 Keys 1,2,A,B then 5,B -> num_1=8'hF4 (-12), num_2=8'h05, valid high exactly 1 cycle; after mult_ready -> DONE, busy=0.
REQ-039 Keys 1,2,9,B -> err pulse, num_1=0, state ENTRY_A; keys A,1,2,8,B -> num_1=8'h80.
REQ-040 Keys 1,2,3,4 -> entry_mag=123 (4th digit ignored); key C -> entry_mag=0, entry_neg=0.
REQ-041 Reset low during WAIT, then key and mult_ready pulses -> ENTRY_A, all outputs 0, valid never asserted.
REQ-042 In DONE: key B -> valid pulse, same operands; key 7 -> ENTRY_A with entry_mag=7.
REQ-043 With MULT_TIMEOUT_EN and TIMEOUT_CYCLES=8, no mult_ready -> err pulse 8 cycles after WAIT entry, ENTRY_A, num_1=num_2=0.
